// File: rtl/stage_cfg_pkg.sv
// Shared constants for the RMT stage configuration writer: opcodes, FSM states,
// payload beat counts and header field positions.
package stage_cfg_pkg;

    localparam logic [7:0] OP_KEY_OFF = 8'd1;
    localparam logic [7:0] OP_LOOKUP  = 8'd2;
    localparam logic [7:0] OP_ACTION  = 8'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DRAIN
    } state_t;

    localparam int unsigned NW_KEY_OFF = 1;
    localparam int unsigned NW_LOOKUP  = 7;
    localparam int unsigned NW_ACTION  = 10;
    localparam int unsigned NW_MAX     = 10;

    localparam int unsigned HDR_OP_LSB  = 56;
    localparam int unsigned HDR_STG_LSB = 48;

    typedef logic [3:0] beat_cnt_t;

    function automatic logic op_valid(input logic [7:0] op);
        return (op == OP_KEY_OFF) || (op == OP_LOOKUP) || (op == OP_ACTION);
    endfunction

    // Index of the final payload beat for an opcode (counter load value).
    function automatic beat_cnt_t last_beat(input logic [7:0] op);
        case (op)
            OP_KEY_OFF: return beat_cnt_t'(NW_KEY_OFF - 1);
            OP_LOOKUP:  return beat_cnt_t'(NW_LOOKUP - 1);
            OP_ACTION:  return beat_cnt_t'(NW_ACTION - 1);
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/stage_cfg_writer_if.sv
// AXI-Stream control channel into a stage configuration writer.
interface stage_cfg_writer_if #(
    parameter int unsigned C_DATA_W = 64
);
    logic [C_DATA_W-1:0] tdata;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cfg_payload_shifter.sv
// Payload shift register: beats enter at the top word and move down, so after N
// beats the packet occupies the top N words, first beat lowest.
module cfg_payload_shifter #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic [W-1:0]       din,
    output logic [W*DEPTH-1:0] shifted
);
    logic [W*DEPTH-1:0] data;

    // Exposes the post-shift image so the final beat can be committed in the same edge.
    always_comb shifted = {din, data[W*DEPTH-1:W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        data <= '0;
        else if (clear) data <= '0;
        else if (load)  data <= shifted;
    end
endmodule

// File: rtl/stage_cfg_writer.sv
// Control-plane writer for one RMT stage: parses config packets and drives the
// key-offset, TCAM and action RAM write ports. Optional STAGE_CFG_ERR_CNT_EN adds err_cnt.
module stage_cfg_writer
    import stage_cfg_pkg::*;
#(
    parameter int unsigned STAGE    = 0,
    parameter int unsigned C_DATA_W = 64,
    parameter int unsigned KEY_LEN  = 197,
    parameter int unsigned KEY_OFF  = 18,
    parameter int unsigned ACT_LEN  = 25,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                   axis_clk,
    input  logic                   areset,
    stage_cfg_writer_if.slave      ctrl,
    output logic [KEY_OFF-1:0]     key_offset_out,
    output logic [ADDR_W-1:0]      key_offset_addr,
    output logic                   key_offset_valid_out,
    output logic [KEY_LEN-1:0]     lookup_din,
    output logic [KEY_LEN-1:0]     lookup_din_mask,
    output logic [ADDR_W-1:0]      lookup_din_addr,
    output logic                   lookup_din_en,
    output logic [ACT_LEN*25-1:0]  action_data_out,
    output logic [ADDR_W-1:0]      action_addr,
    output logic                   action_en
`ifdef STAGE_CFG_ERR_CNT_EN
    ,
    output logic [15:0]            err_cnt
`endif
);
    localparam int unsigned PAY_W   = C_DATA_W * NW_MAX;
    localparam int unsigned BASE_KO = C_DATA_W * (NW_MAX - NW_KEY_OFF);
    localparam int unsigned BASE_LK = C_DATA_W * (NW_MAX - NW_LOOKUP);
    localparam int unsigned BASE_AC = C_DATA_W * (NW_MAX - NW_ACTION);

    state_t            state, state_next;
    beat_cnt_t         cnt;
    logic [7:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [PAY_W-1:0]  shifted;

    logic       beat, last_exp, hdr_match, commit;
    logic [7:0] hdr_op, hdr_stg;

    always_comb begin
        beat      = ctrl.tvalid && ctrl.tready;
        hdr_op    = ctrl.tdata[HDR_OP_LSB +: 8];
        hdr_stg   = ctrl.tdata[HDR_STG_LSB +: 8];
        hdr_match = (hdr_stg == 8'(STAGE)) && op_valid(hdr_op);
        last_exp  = (cnt == '0);
        commit    = (state == ST_COLLECT) && beat && last_exp && ctrl.tlast;
    end

    cfg_payload_shifter #(.W(C_DATA_W), .DEPTH(NW_MAX)) u_shifter (
        .clk     (axis_clk),
        .rst     (areset),
        .clear   ((state == ST_IDLE) && beat),
        .load    ((state == ST_COLLECT) && beat),
        .din     (ctrl.tdata),
        .shifted (shifted)
    );

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:
                if (beat && !ctrl.tlast) state_next = hdr_match ? ST_COLLECT : ST_DRAIN;
            ST_COLLECT:
                if (beat) begin
                    if (last_exp)         state_next = ctrl.tlast ? ST_WRITE : ST_DRAIN;
                    else if (ctrl.tlast)  state_next = ST_IDLE;
                end
            ST_WRITE:
                state_next = ST_IDLE;
            ST_DRAIN:
                if (beat && ctrl.tlast) state_next = ST_IDLE;
            default:
                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl.tready          = !areset && (state != ST_WRITE);
        key_offset_valid_out = (state == ST_WRITE) && (op == OP_KEY_OFF);
        lookup_din_en        = (state == ST_WRITE) && (op == OP_LOOKUP);
        action_en            = (state == ST_WRITE) && (op == OP_ACTION);
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            cnt  <= '0;
            op   <= '0;
            addr <= '0;
        end else if ((state == ST_IDLE) && beat) begin
            cnt  <= last_beat(hdr_op);
            op   <= hdr_op;
            addr <= ctrl.tdata[ADDR_W-1:0];
        end else if ((state == ST_COLLECT) && beat && !last_exp) begin
            cnt  <= cnt - 1'b1;
        end
    end

    // Output registers load on the final beat so they are valid during the strobe cycle.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            key_offset_out  <= '0;
            key_offset_addr <= '0;
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= '0;
            action_data_out <= '0;
            action_addr     <= '0;
        end else if (commit) begin
            case (op)
                OP_KEY_OFF: begin
                    key_offset_out  <= shifted[BASE_KO +: KEY_OFF];
                    key_offset_addr <= addr;
                end
                OP_LOOKUP: begin
                    lookup_din      <= shifted[BASE_LK +: KEY_LEN];
                    lookup_din_mask <= shifted[BASE_LK + KEY_LEN +: KEY_LEN];
                    lookup_din_addr <= addr;
                end
                OP_ACTION: begin
                    action_data_out <= shifted[BASE_AC +: ACT_LEN*25];
                    action_addr     <= addr;
                end
                default: ;
            endcase
        end
    end

`ifdef STAGE_CFG_ERR_CNT_EN
    logic err_evt;

    always_comb
        err_evt = ((state == ST_IDLE) && beat && ctrl.tlast && hdr_match) ||
                  ((state == ST_COLLECT) && beat && (last_exp ? !ctrl.tlast : ctrl.tlast));

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset)                        err_cnt <= '0;
        else if (err_evt && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
`endif
endmodule
